// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package md_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl.sv
// Sequences MULT/DIV through the external multiplier/divider, owns HI/LO and
// requests an EX stall while an operation is in flight.
module md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        annul,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready
);

  md_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_opa;
  logic [31:0]        r_opb;
  logic               r_signed;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic w_idle;
  logic w_mul_wait;
  logic w_div_wait;
  logic w_is_mul;
  logic w_is_div;
  logic w_div_zero;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_mul_wait = (r_state == ST_MUL_WAIT);
  assign w_div_wait = (r_state == ST_DIV_WAIT);
  assign w_is_mul   = is_mul_op(op);
  assign w_is_div   = is_div_op(op);
  assign w_div_zero = (src_b == 32'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (annul) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            if (w_is_mul) begin
              r_opa    <= src_a;
              r_opb    <= src_b;
              r_signed <= (op == OP_MULT);
              r_cnt    <= CNT_W'(MUL_LAT);
              r_state  <= ST_MUL_WAIT;
            end else if (w_is_div && !w_div_zero) begin
              r_opa    <= src_a;
              r_opb    <= src_b;
              r_signed <= (op == OP_DIV);
              r_state  <= ST_DIV_WAIT;
            end else if (op == OP_MTHI) begin
              r_hi <= src_a;
            end else if (op == OP_MTLO) begin
              r_lo <= src_a;
            end
          end
        end
        ST_MUL_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            {r_hi, r_lo} <= mul_result;
            r_state      <= ST_DONE;
          end
        end
        ST_DIV_WAIT: begin
          if (div_ready) begin
            r_hi    <= div_result[63:32];
            r_lo    <= div_result[31:0];
            r_state <= ST_DONE;
          end
        end
        // EX still presents the finished instruction here, so op_valid is ignored.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stallreq = resetn && !annul &&
                    ((w_idle && op_valid && (w_is_mul || (w_is_div && !w_div_zero))) ||
                     w_mul_wait ||
                     (w_div_wait && !div_ready));

  assign busy       = !w_idle;
  assign hi         = r_hi;
  assign lo         = r_lo;

  assign mul_signed = w_mul_wait && r_signed;
  assign mul_ina    = w_mul_wait ? r_opa : 32'd0;
  assign mul_inb    = w_mul_wait ? r_opb : 32'd0;

  assign div_start  = w_div_wait && !div_ready;
  assign div_signed = w_div_wait && r_signed;
  assign div_opa    = w_div_wait ? r_opa : 32'd0;
  assign div_opb    = w_div_wait ? r_opb : 32'd0;
  assign div_annul  = annul && w_div_wait;

endmodule
